// File: rtl/mtx_seq_ctrl.sv
// Transmit sequencer: multi-phase GPIO sync preamble followed by a gated IQ
// burst, with repeated bursts, optional external trigger, abort and
// backpressure. All sequencing advances only on beats; everything else stalls.
module mtx_seq_ctrl #(
  parameter int                        DATA_WIDTH     = 16,
  parameter int                        GPIO_REG_WIDTH = 12,
  parameter int                        CNT_WIDTH      = 24,
  parameter int                        NSYNC          = 3,
  parameter int                        SYNC_LEN       = 8400,
  parameter logic [7:0]                SYNC_PATTERN   = 8'b0000_0011,
  parameter logic [7:0]                BLANK_PATTERN  = 8'b0000_0100,
  parameter int                        TX_LEN         = 40960,
  parameter int                        NREP           = 0,
  parameter logic [GPIO_REG_WIDTH-1:0] SYNC_OUT_MASK  = 12'h001,
  parameter logic [GPIO_REG_WIDTH-1:0] TX_OUT_MASK    = 12'h010,
  parameter logic [GPIO_REG_WIDTH-1:0] TRIG_IN_MASK   = 12'h040
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      use_ext_trig,
  input  logic [GPIO_REG_WIDTH-1:0] gpio_in,
  input  logic [DATA_WIDTH-1:0]     i_in,
  input  logic [DATA_WIDTH-1:0]     q_in,
  input  logic                      in_tvalid,
  output logic                      in_tready,
  output logic [DATA_WIDTH-1:0]     itx,
  output logic [DATA_WIDTH-1:0]     qtx,
  output logic                      tx_valid,
  input  logic                      tx_tready,
  output logic [GPIO_REG_WIDTH-1:0] gpio_out,
  output logic                      src_srst,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      burst_cnt,
  output logic [2:0]                phase_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SYNC, S_TX} state_t;

  localparam logic [CNT_WIDTH-1:0] SYNC_LAST  = CNT_WIDTH'(SYNC_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] TX_LAST    = CNT_WIDTH'(TX_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] NREP_C     = CNT_WIDTH'(NREP);
  localparam logic [2:0]           PHASE_LAST = 3'(NSYNC - 1);
  localparam bit                   TX_BOUNDED = (TX_LEN != 0);
  localparam bit                   NREP_EN    = (NREP != 0);

  state_t                    state, state_nxt;
  logic [2:0]                phase_nxt;
  logic [CNT_WIDTH-1:0]      cnt, cnt_nxt, burst_nxt, burst_inc;
  logic [GPIO_REG_WIDTH-1:0] gpio_nxt;
  logic                      srst_nxt, done_nxt;
  logic                      in_run, blank, beat, trig, trig_q, trig_edge;

  // Blanked cycles (IDLE/ARM or a blanked sync phase) need no upstream data,
  // so only the radio's ready gates a beat there.
  assign in_run    = (state == S_SYNC) || (state == S_TX);
  assign blank     = ((state == S_SYNC) && BLANK_PATTERN[phase_idx]) ||
                     (state == S_IDLE) || (state == S_ARM);
  assign beat      = tx_tready && (blank || in_tvalid);
  assign trig      = |(gpio_in & TRIG_IN_MASK);
  assign trig_edge = trig && !trig_q;
  assign burst_inc = burst_cnt + CNT_WIDTH'(1);

  // Zero-latency IQ path.
  assign itx       = blank ? '0 : i_in;
  assign qtx       = blank ? '0 : q_in;
  assign tx_valid  = in_run && (blank || in_tvalid);
  assign in_tready = in_run && tx_tready;
  assign busy      = (state != S_IDLE);

  // Next-state, counters and registered-output values; abort overrides all.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase_idx;
    cnt_nxt   = cnt;
    burst_nxt = burst_cnt;
    done_nxt  = 1'b0;
    if (abort) begin
      // Clean IDLE; burst count is kept for software to read back.
      state_nxt = S_IDLE;
      phase_nxt = '0;
      cnt_nxt   = '0;
    end else if (beat) begin
      case (state)
        S_IDLE: if (start) begin
          state_nxt = use_ext_trig ? S_ARM : S_SYNC;
          burst_nxt = '0;
          phase_nxt = '0;
          cnt_nxt   = '0;
        end
        S_ARM: if (trig_edge) state_nxt = S_SYNC;
        S_SYNC: begin
          if (cnt == SYNC_LAST) begin
            cnt_nxt   = '0;
            phase_nxt = phase_idx + 3'd1;
            if (phase_idx == PHASE_LAST) state_nxt = S_TX;
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end
        S_TX: begin
          if (TX_BOUNDED && (cnt == TX_LAST)) begin
            cnt_nxt   = '0;
            phase_nxt = '0;
            burst_nxt = burst_inc;
            if (NREP_EN && (burst_inc == NREP_C)) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = use_ext_trig ? S_ARM : S_SYNC;
            end
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    // GPIO and tone-generator reset follow the state being entered.
    gpio_nxt = '0;
    if ((state_nxt == S_SYNC) && SYNC_PATTERN[phase_nxt])
      gpio_nxt = gpio_nxt | SYNC_OUT_MASK;
    if (((state_nxt == S_SYNC) && !BLANK_PATTERN[phase_nxt]) || (state_nxt == S_TX))
      gpio_nxt = gpio_nxt | TX_OUT_MASK;
    srst_nxt = (state_nxt != S_TX);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_idx <= '0;
      cnt       <= '0;
      burst_cnt <= '0;
      gpio_out  <= '0;
      src_srst  <= 1'b1;
      done      <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_idx <= phase_nxt;
      cnt       <= cnt_nxt;
      burst_cnt <= burst_nxt;
      gpio_out  <= gpio_nxt;
      src_srst  <= srst_nxt;
      done      <= done_nxt;
      trig_q    <= trig;
    end
  end

endmodule

// File: tb/tb_mtx_seq_ctrl.sv
// Bench for mtx_seq_ctrl: burst-position reference model + scoreboard queues,
// directed latency / stall / unbounded-TX / async-reset scenarios.
module tb_mtx_seq_ctrl;
  localparam int DW = 16, GW = 12, CW = 24;
  localparam int NSYNC = 3, SLEN = 4, TXL = 8, NREP = 3;
  localparam logic [7:0]    SPAT = 8'b0000_0011, BPAT = 8'b0000_0100;
  localparam logic [GW-1:0] SMASK = 12'h001, TMASK = 12'h010, TRMASK = 12'h040;
  localparam int SYNC_BEATS = NSYNC * SLEN;
  localparam int BURST      = SYNC_BEATS + TXL;

  logic clk, reset, start, abort, use_ext_trig, in_tvalid, tx_tready;
  logic [GW-1:0] gpio_in;
  logic [DW-1:0] i_in, q_in;
  logic in_tready, tx_valid, src_srst, busy, done;
  logic [DW-1:0] itx, qtx;
  logic [GW-1:0] gpio_out;
  logic [CW-1:0] burst_cnt;
  logic [2:0]    phase_idx;

  logic f_reset, f_start, f_abort, f_ext;
  logic f_in_tready, f_tx_valid, f_src_srst, f_busy, f_done;
  logic [DW-1:0] f_itx, f_qtx;
  logic [GW-1:0] f_gpio_out;
  logic [CW-1:0] f_burst_cnt;
  logic [2:0]    f_phase_idx;
  bit f_done_seen;

  mtx_seq_ctrl #(.DATA_WIDTH(DW), .GPIO_REG_WIDTH(GW), .CNT_WIDTH(CW), .NSYNC(NSYNC),
    .SYNC_LEN(SLEN), .SYNC_PATTERN(SPAT), .BLANK_PATTERN(BPAT), .TX_LEN(TXL), .NREP(NREP),
    .SYNC_OUT_MASK(SMASK), .TX_OUT_MASK(TMASK), .TRIG_IN_MASK(TRMASK)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .use_ext_trig(use_ext_trig),
    .gpio_in(gpio_in), .i_in(i_in), .q_in(q_in), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .itx(itx), .qtx(qtx), .tx_valid(tx_valid), .tx_tready(tx_tready), .gpio_out(gpio_out),
    .src_srst(src_srst), .busy(busy), .done(done), .burst_cnt(burst_cnt), .phase_idx(phase_idx));

  // Unbounded-TX, continuous-mode instance for directed checks.
  mtx_seq_ctrl #(.DATA_WIDTH(DW), .GPIO_REG_WIDTH(GW), .CNT_WIDTH(CW), .NSYNC(NSYNC),
    .SYNC_LEN(SLEN), .SYNC_PATTERN(SPAT), .BLANK_PATTERN(BPAT), .TX_LEN(0), .NREP(0),
    .SYNC_OUT_MASK(SMASK), .TX_OUT_MASK(TMASK), .TRIG_IN_MASK(TRMASK)) u_inf (
    .clk(clk), .reset(f_reset), .start(f_start), .abort(f_abort), .use_ext_trig(f_ext),
    .gpio_in(gpio_in), .i_in(i_in), .q_in(q_in), .in_tvalid(in_tvalid), .in_tready(f_in_tready),
    .itx(f_itx), .qtx(f_qtx), .tx_valid(f_tx_valid), .tx_tready(tx_tready), .gpio_out(f_gpio_out),
    .src_srst(f_src_srst), .busy(f_busy), .done(f_done), .burst_cnt(f_burst_cnt),
    .phase_idx(f_phase_idx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (f_done) f_done_seen <= 1'b1;

  int checks, errors;
  bit chk_on;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: a burst is one flat run of BURST beats; position within
  // it determines phase, sync/TX region and GPIO drive.
  typedef struct { bit tv, itr, busy, srst, dn; logic [GW-1:0] gpio; logic [2:0] ph; logic [CW-1:0] bc; } stat_t;
  typedef struct { logic [DW-1:0] i, q; } beat_t;
  stat_t sq[$];
  beat_t bq[$];
  int m_mode;   // 0 idle, 1 waiting for trigger, 2 running a burst
  int m_pos, m_bursts;
  bit m_tprev, m_done;

  function automatic int m_ph();
    if (m_mode != 2) return 0;
    if (m_pos < SYNC_BEATS) return m_pos / SLEN;
    return NSYNC % 8;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_bursts = 0; m_tprev = 0; m_done = 0;
  endtask

  task automatic model_step();
    stat_t s; beat_t b;
    bit run, insync, blank, bt, trig;
    int ph;
    logic [7:0] sp, bp;
    sp = SPAT; bp = BPAT;
    run = (m_mode == 2); insync = run && (m_pos < SYNC_BEATS); ph = m_ph();
    blank = !run || (insync && bp[ph]);
    bt = tx_tready && (blank || in_tvalid);
    s.tv = run && (blank || in_tvalid);
    s.itr = run && tx_tready;
    if (s.tv && tx_tready) begin
      b.i = blank ? '0 : i_in; b.q = blank ? '0 : q_in;
      bq.push_back(b);
    end
    trig = |(gpio_in & TRMASK);
    m_done = 0;
    if (abort) begin
      m_mode = 0; m_pos = 0;
    end else if (bt) begin
      case (m_mode)
        0: if (start) begin m_bursts = 0; m_pos = 0; m_mode = use_ext_trig ? 1 : 2; end
        1: if (trig && !m_tprev) begin m_mode = 2; m_pos = 0; end
        default: begin
          if (m_pos + 1 < BURST) m_pos++;
          else begin
            m_bursts++; m_pos = 0;
            if (m_bursts == NREP) begin m_mode = 0; m_done = 1; end
            else m_mode = use_ext_trig ? 1 : 2;
          end
        end
      endcase
    end
    m_tprev = trig;
    run = (m_mode == 2); insync = run && (m_pos < SYNC_BEATS); ph = m_ph();
    s.busy = (m_mode != 0);
    s.srst = !(run && !insync);
    s.dn = m_done;
    s.ph = ph[2:0];
    s.bc = m_bursts[CW-1:0];
    s.gpio = ((insync && sp[ph]) ? SMASK : '0) | (((insync && !bp[ph]) || (run && !insync)) ? TMASK : '0);
    sq.push_back(s);
  endtask

  // Monitor: combinational outputs just before the edge, registered after it.
  initial begin
    stat_t s; beat_t b;
    forever begin
      @(negedge clk); #3;
      if (chk_on && sq.size() != 0) begin
        chk("tx_valid", tx_valid, sq[0].tv);
        chk("in_tready", in_tready, sq[0].itr);
        if (tx_valid && tx_tready) begin
          if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_unexpected got itx %0h want none", itx);
          end else begin
            b = bq.pop_front();
            chk("itx", itx, b.i);
            chk("qtx", qtx, b.q);
          end
        end
      end
      @(posedge clk); #1;
      if (chk_on && sq.size() != 0) begin
        s = sq.pop_front();
        chk("busy", busy, s.busy);
        chk("gpio_out", gpio_out, s.gpio);
        chk("src_srst", src_srst, s.srst);
        chk("done", done, s.dn);
        chk("phase_idx", phase_idx, s.ph);
        chk("burst_cnt", burst_cnt, s.bc);
      end
    end
  end

  // Start at full throughput (optionally stalling the radio) and time done.
  task automatic measure(input int stall_at, input int stall_len, input int exp_lat, input string nm);
    int lat;
    lat = -1;
    @(negedge clk);
    start = 1; abort = 0; use_ext_trig = 0; tx_tready = 1; in_tvalid = 1;
    i_in = DW'($urandom); q_in = DW'($urandom);
    model_step();
    for (int n = 0; n < 10 * BURST; n++) begin
      @(negedge clk);
      start = 0;
      tx_tready = !(n >= stall_at && n < stall_at + stall_len);
      i_in = DW'($urandom); q_in = DW'($urandom);
      if (done && lat < 0) lat = n;
      model_step();
      if (lat >= 0) break;
    end
    chk(nm, lat, exp_lat);
  endtask

  initial begin
    logic [GW-1:0] g;
    bit ext;
    int rdy_pct;
    checks = 0; errors = 0; chk_on = 0;
    reset = 1; f_reset = 1; start = 0; abort = 0; use_ext_trig = 0; f_start = 0; f_abort = 0;
    f_ext = 0; gpio_in = '0; i_in = 16'h1234; q_in = 16'h5678; in_tvalid = 1; tx_tready = 1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);       chk("rst_gpio", gpio_out, 0);
    chk("rst_srst", src_srst, 1);   chk("rst_done", done, 0);
    chk("rst_bc", burst_cnt, 0);    chk("rst_phase", phase_idx, 0);
    chk("rst_tx_valid", tx_valid, 0); chk("rst_in_tready", in_tready, 0);
    chk("rst_itx", itx, 0);         chk("rst_f_busy", f_busy, 0);
    reset = 0; f_reset = 0; chk_on = 1;

    measure(0, 0, NREP * BURST, "done_latency");
    measure(6, 5, NREP * BURST + 5, "done_latency_stall5");

    for (int seg = 0; seg < 30; seg++) begin
      ext = 1'($urandom_range(0, 1));
      rdy_pct = $urandom_range(60, 100);
      for (int c = 0; c < 120; c++) begin
        @(negedge clk);
        use_ext_trig = ext;
        start = ($urandom_range(0, 9) == 0);
        abort = ($urandom_range(0, 199) == 0);
        if (seg == 5 && c == 40) begin start = 1; abort = 1; end
        tx_tready = ($urandom_range(1, 100) <= rdy_pct);
        in_tvalid = ($urandom_range(0, 7) != 0);
        i_in = DW'($urandom); q_in = DW'($urandom);
        g = GW'($urandom);
        g[6] = gpio_in[6] ^ ($urandom_range(0, 5) == 0);
        gpio_in = g;
        model_step();
      end
    end
    @(posedge clk); #3;
    chk("beat_queue_drained", bq.size(), 0);
    chk("stat_queue_drained", sq.size(), 0);
    chk_on = 0;

    // Async reset in the middle of sync phase 1.
    @(negedge clk); abort = 1; start = 0; tx_tready = 1; in_tvalid = 1; use_ext_trig = 0;
    gpio_in = '0; i_in = 16'h1234; q_in = 16'h5678;
    @(negedge clk); abort = 0; start = 1;
    @(negedge clk); start = 0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_phase", phase_idx, 1);
    #2 reset = 1;
    #1;
    chk("arst_busy", busy, 0);     chk("arst_gpio", gpio_out, 0);
    chk("arst_srst", src_srst, 1); chk("arst_phase", phase_idx, 0);
    chk("arst_done", done, 0);     chk("arst_itx", itx, 0);
    chk("arst_tx_valid", tx_valid, 0);
    @(negedge clk); reset = 0; model_reset();

    // Unbounded TX: only abort leaves it.
    @(negedge clk); f_start = 1;
    @(negedge clk); f_start = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k % 100 == 0) begin
        chk("inf_busy", f_busy, 1);
        chk("inf_srst", f_src_srst, 0);
        chk("inf_gpio", f_gpio_out, TMASK);
        chk("inf_bc", f_burst_cnt, 0);
      end
    end
    @(negedge clk); f_abort = 1; f_start = 1;
    @(negedge clk); f_abort = 0; f_start = 0;
    chk("abort_busy", f_busy, 0);  chk("abort_gpio", f_gpio_out, 0);
    chk("abort_srst", f_src_srst, 1); chk("abort_done", f_done, 0);
    @(negedge clk);
    chk("abort_start_ignored", f_busy, 0);

    @(negedge clk); f_start = 1;
    @(negedge clk); f_start = 0;
    repeat (3) @(negedge clk);
    chk("inf_sync_gpio", f_gpio_out, SMASK | TMASK);
    chk("inf_sync_srst", f_src_srst, 1);
    #2 f_reset = 1;
    #1;
    chk("inf_arst_busy", f_busy, 0);   chk("inf_arst_gpio", f_gpio_out, 0);
    chk("inf_arst_srst", f_src_srst, 1); chk("inf_arst_phase", f_phase_idx, 0);
    chk("inf_never_done", f_done_seen, 0);
    @(negedge clk); f_reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mtx_seq_ctrl.md
Name: mtx_seq_ctrl

Overview:
Parametrised transmit sequencer for the multi-transmitter ANC chain. Runs a programmable multi-phase sync preamble on front-panel GPIO, then gates an upstream IQ tone stream to the radio. Adds repeated bursts, optional external GPIO trigger, abort, and AXI-style backpressure, none of which the single-shot fixed three-phase controller has. Sits between the tone generator (which it holds in sync reset) and the radio TX sample interface / GPIO block.

Parameters:
DATA_WIDTH, 16, IQ sample width.
GPIO_REG_WIDTH, 12, GPIO register width.
CNT_WIDTH, 24, width of beat counters.
NSYNC, 3, number of sync phases (1..8).
SYNC_LEN, 8400, beats per sync phase (>=1).
SYNC_PATTERN, 8'b0000_0011, bit p = sync GPIO level in phase p.
BLANK_PATTERN, 8'b0000_0100, bit p = IQ forced to zero in phase p.
TX_LEN, 40960, beats in TX state; 0 = unbounded (until abort).
NREP, 0, bursts per start; 0 = continuous.
SYNC_OUT_MASK, 12'h001, GPIO bits driven by sync level.
TX_OUT_MASK, 12'h010, GPIO bits marking TX-active.
TRIG_IN_MASK, 12'h040, GPIO input bits OR-ed to form external trigger.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
start  in  1  pulse: begin sequence (ignored unless IDLE).
abort  in  1  pulse: return to IDLE from any state.
use_ext_trig  in  1  1 = wait in ARM for trigger rising edge before each burst.
gpio_in  in  GPIO_REG_WIDTH  GPIO inputs, already synchronised to clk.
i_in, q_in  in  DATA_WIDTH each  upstream IQ.
in_tvalid  in  1  upstream valid.
in_tready  out  1  upstream ready.
itx, qtx  out  DATA_WIDTH each  IQ to radio.
tx_valid  out  1  IQ valid.
tx_tready  in  1  radio ready.
gpio_out  out  GPIO_REG_WIDTH  registered GPIO drive.
src_srst  out  1  sync reset to tone generator.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse when NREP bursts complete.
burst_cnt  out  CNT_WIDTH  completed bursts since start.
phase_idx  out  3  current sync phase.

Behaviour:
- States: IDLE, ARM, SYNC, TX. Reset: IDLE, phase_idx=0, beat counter=0, burst_cnt=0, gpio_out=0, src_srst=1, done=0.
- beat = tx_tready && (blank || in_tvalid); blank = (SYNC && BLANK_PATTERN[phase_idx]) || IDLE || ARM. Counters and state advance only on beats; all else holds (stall).
- IQ path combinational, zero latency: itx/qtx = blank ? 0 : i_in/q_in; tx_valid = SYNC||TX ? (blank | in_tvalid) : 0; in_tready = (SYNC||TX) && tx_tready.
- IDLE: start -> ARM if use_ext_trig else SYNC; burst_cnt cleared to 0, phase_idx=0, counter=0.
- ARM: trigger = |(gpio_in & TRIG_IN_MASK); rising edge (registered previous value) -> SYNC. Level already high on entry does not fire.
- SYNC: counter counts 0..SYNC_LEN-1 per phase; at last beat counter=0, phase_idx++; after phase NSYNC-1 -> TX.
- TX: counter counts TX_LEN beats (unbounded if TX_LEN=0). At last beat burst_cnt++; if NREP!=0 and burst_cnt+1==NREP -> IDLE, done pulses same edge; else -> ARM (use_ext_trig) or SYNC, phase_idx=0.
- Counter width: CNT_WIDTH; burst_cnt wraps silently at 2^CNT_WIDTH in continuous mode.
- src_srst registered: 1 in IDLE/ARM/SYNC, 0 in TX; falls on edge entering TX.
- gpio_out registered from next-state: SYNC_OUT_MASK if SYNC and SYNC_PATTERN[phase_idx]; TX_OUT_MASK if (SYNC and not blank) or TX; else 0.
- abort: takes priority over start and all transitions; next edge IDLE, gpio_out=0, src_srst=1, no done, burst_cnt held.
- start while busy ignored; start+abort same cycle -> IDLE.
- Async reset mid-burst: immediate return to reset values, no done.

Test Plan:
- SYNC_LEN=4, NSYNC=3, TX_LEN=8, NREP=1, tready/tvalid=1, start -> sync bit high 8 cycles, TX bit high phases 0-1, IQ=0 for 4 cycles in phase 2, src_srst falls at cycle 12, 8 TX beats, done at cycle 20, burst_cnt=1.
- Same, NREP=3 -> three back-to-back bursts, done once after burst 3, burst_cnt=3.
- tx_tready low 5 cycles mid phase 1 -> counter/phase/gpio frozen; sequence end delayed exactly 5 cycles.
- use_ext_trig=1, gpio_in[6] held high before start -> stays ARM; drop then raise -> SYNC next cycle.
- abort in TX at beat 3 -> IDLE next edge, gpio_out=0, src_srst=1, no done; start coincident with abort ignored.
- TX_LEN=0 -> TX persists 1000 cycles, only abort exits; async reset mid-SYNC -> all outputs at reset values immediately.
